// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Digit corrector thresholds live here so the engine and corrector agree.
package bin2bcd_pkg;

  localparam int W_DEF = 8;
  localparam int ND_DEF = 3;
  localparam int CNT_W = $clog2(W_DEF) + 1;

  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_VAL = 3;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_8bit_add3.sv
// Double-dabble digit corrector: a digit of 5 or more gets +3
// so that the following left shift carries cleanly into the next digit.
module bcd_add3_corr
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'(BCD_ADJ_THRESH))
             ? digit + 4'(BCD_ADJ_VAL)
             : digit;

endmodule

// File: rtl/bin2bcd_seq_8bit.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Signed inputs are shown as sign plus magnitude; outputs update only at done.
module bin2bcd_seq_8bit
  import bin2bcd_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int ND = ND_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    din,
  input  logic            is_signed,
  output logic            busy,
  output logic            done,
  output logic            neg,
  output logic [4*ND-1:0] bcd
);

  localparam int CW = $clog2(W) + 1;

  state_t          state;
  logic [W-1:0]    bin_sr;
  logic [4*ND-1:0] scr;
  logic [4*ND-1:0] scr_adj;
  logic [4*ND-1:0] scr_nxt;
  logic [CW-1:0]   cnt;
  logic            neg_capt;
  logic            neg_in;
  logic [W-1:0]    mag;
  logic            last;

  // Sign and magnitude of the incoming value; 0x80 signed yields 128.
  always_comb begin
    neg_in = is_signed & din[W-1];
    mag = din;
    if (neg_in) mag = ~din + W'(1);
  end

  for (genvar i = 0; i < ND; i++) begin : g_corr
    bcd_add3_corr u_corr (
      .digit(scr[4*i +: 4]),
      .adj  (scr_adj[4*i +: 4])
    );
  end

  assign scr_nxt = {scr_adj[4*ND-2:0], bin_sr[W-1]};
  assign last = (cnt == CW'(W - 1));

  // Conversion FSM: capture on start, W correct-and-shift steps, publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bin_sr <= '0;
      scr <= '0;
      cnt <= '0;
      neg_capt <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      neg <= 1'b0;
      bcd <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= mag;
            neg_capt <= neg_in;
            scr <= '0;
            cnt <= '0;
            busy <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          scr <= scr_nxt;
          bin_sr <= {bin_sr[W-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (last) begin
            bcd <= scr_nxt;
            neg <= neg_capt;
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_8bit.sv
// Directed self-checking bench for bin2bcd_seq_8bit.
// Hand-computed BCD vectors, handshake timing, input stability, reset abort.
module tb_bin2bcd_seq_8bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  din;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic        neg;
  logic [11:0] bcd;

  int n_chk;
  int n_pass;

  bin2bcd_seq_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .din      (din),
    .is_signed(is_signed),
    .busy     (busy),
    .done     (done),
    .neg      (neg),
    .bcd      (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every published digit must be a legal decimal digit.
  always @(negedge clk) begin
    if (rst_n && done) begin
      for (int i = 0; i < 3; i++) begin
        assert (bcd[i*4 +: 4] <= 4'd9)
          else $error("bcd digit %0d out of range: %0h", i, bcd);
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Called at a negedge; returns at the negedge after the done pulse ends.
  task automatic run(input string tag,
                     input logic [7:0] d,
                     input logic s,
                     input logic [11:0] eb,
                     input logic en);
    logic ok;
    start = 1'b1;
    din = d;
    is_signed = s;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!busy || done) ok = 1'b0;
    end
    check({tag, "_busy_win"}, 32'(ok), 32'd1);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'(eb));
    check({tag, "_neg"}, 32'(neg), 32'(en));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic ok;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    start = 1'b0;
    din = 8'h00;
    is_signed = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("u_ff", 8'hFF, 1'b0, 12'h255, 1'b0);
    run("s_80", 8'h80, 1'b1, 12'h128, 1'b1);
    run("s_7f", 8'h7F, 1'b1, 12'h127, 1'b0);
    run("s_ff", 8'hFF, 1'b1, 12'h001, 1'b1);
    run("s_00", 8'h00, 1'b1, 12'h000, 1'b0);
    run("u_9c", 8'h9C, 1'b0, 12'h156, 1'b0);
    run("s_9c", 8'h9C, 1'b1, 12'h100, 1'b1);

    // Start during busy is ignored.
    start = 1'b1;
    din = 8'h2A;
    is_signed = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!busy || done) ok = 1'b0;
    end
    start = 1'b1;
    din = 8'h63;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!busy || done) ok = 1'b0;
    end
    check("ign_busy_win", 32'(ok), 32'd1);
    @(negedge clk);
    check("ign_done", 32'(done), 32'd1);
    check("ign_bcd", 32'(bcd), 32'h042);

    // Start during the done cycle is accepted.
    run("b2b_63", 8'h63, 1'b0, 12'h099, 1'b0);

    // din and is_signed wander during CONV; bcd holds until done.
    start = 1'b1;
    din = 8'hC8;
    is_signed = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      din = (c == 0) ? 8'h00 : 8'($urandom);
      is_signed = 1'($urandom);
      @(negedge clk);
      if (!busy || done || bcd !== 12'h099) ok = 1'b0;
    end
    check("stab_hold", 32'(ok), 32'd1);
    @(negedge clk);
    check("stab_done", 32'(done), 32'd1);
    check("stab_bcd", 32'(bcd), 32'h200);
    check("stab_neg", 32'(neg), 32'd0);

    // Asynchronous abort mid-conversion.
    start = 1'b1;
    din = 8'hFF;
    is_signed = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_neg", 32'(neg), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) ok = 1'b0;
    end
    check("abort_no_done", 32'(ok), 32'd1);

    run("post_rst_01", 8'h01, 1'b0, 12'h001, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
